// File: rtl/instr_pair_queue.sv
// Instruction-pair queue: a circular buffer of {instr1, instr2} entries whose head
// can be consumed one instruction at a time. The half flag records that
// the head's instr1 has already been taken.
module instr_pair_queue #(
    parameter int unsigned DEPTH = 8,
    parameter logic [0:31] NOP   = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [0:31]              in_instr1,
    input  logic [0:31]              in_instr2,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [0:31]              out_instr1,
    output logic [0:31]              out_instr2,
    output logic                     out_single,
    input  logic [0:1]               out_take,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
    localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

    logic [0:31]   instr1_q [DEPTH];
    logic [0:31]   instr2_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          half_q, half_d;

    logic push, pop_full, pop_half;
    logic [0:31] head_instr1, head_instr2;

    assign in_ready    = (count_q != CntFull);
    assign out_valid   = (count_q != '0);
    assign count       = count_q;
    assign head_instr1 = instr1_q[rd_ptr_q];
    assign head_instr2 = instr2_q[rd_ptr_q];

    // Handshake decode; a flush suppresses the push so the presented pair is dropped.
    always_comb begin
        push     = in_valid && in_ready && !flush;
        pop_full = out_valid && ((out_take == 2'b11) || ((out_take == 2'b10) && half_q));
        pop_half = out_valid && (out_take == 2'b10) && !half_q;
    end

    // Next-state for pointers, occupancy and the half-consumed flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        half_d   = half_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            half_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop_full) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
                half_d   = 1'b0;
            end else if (pop_half) begin
                half_d = 1'b1;
            end
            unique case ({push, pop_full})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            half_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            half_q   <= half_d;
        end
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            instr1_q[wr_ptr_q] <= in_instr1;
            instr2_q[wr_ptr_q] <= in_instr2;
        end
    end

    // Head view: full pair, remaining instr2 after a half pop, or NOP when empty.
    always_comb begin
        out_instr1 = NOP;
        out_instr2 = NOP;
        out_single = 1'b0;
        if (out_valid) begin
            if (half_q) begin
                out_instr1 = head_instr2;
                out_single = 1'b1;
            end else begin
                out_instr1 = head_instr1;
                out_instr2 = head_instr2;
            end
        end
    end

endmodule

// File: tb/tb_instr_pair_queue.sv
// Self-checking bench for instr_pair_queue: a directed vector table followed by
// hand-written sequences checked against a small queue model.
module tb_instr_pair_queue;

    localparam int unsigned DEPTH = 8;
    localparam logic [0:31] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [0:31] in_instr1 = '0;
    logic [0:31] in_instr2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [0:31] out_instr1;
    logic [0:31] out_instr2;
    logic        out_single;
    logic [0:1]  out_take = 2'b00;
    logic        flush = 1'b0;
    logic [3:0]  count;

    int nchk = 0;
    int nerr = 0;

    instr_pair_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr1  (in_instr1),
        .in_instr2  (in_instr2),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_instr1 (out_instr1),
        .out_instr2 (out_instr2),
        .out_single (out_single),
        .out_take   (out_take),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [0:31] i1;
        logic [0:31] i2;
        logic [0:1]  take;
        logic        fl;
        logic        e_rdy;
        logic        e_ov;
        logic [0:31] e_o1;
        logic [0:31] e_o2;
        logic        e_s;
        logic [3:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [0:31] i1;
        logic [0:31] i2;
    } pair_t;

    vec_t  tbl [15];
    pair_t q [$];
    bit    mhalf = 1'b0;

    function automatic vec_t mk(logic v, logic [0:31] i1, logic [0:31] i2, logic [0:1] take,
                                logic fl, logic e_rdy, logic e_ov, logic [0:31] e_o1,
                                logic [0:31] e_o2, logic e_s, logic [3:0] e_cnt);
        vec_t r;
        r.v = v; r.i1 = i1; r.i2 = i2; r.take = take; r.fl = fl;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_o1 = e_o1; r.e_o2 = e_o2;
        r.e_s = e_s; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [0:31] i1, input logic [0:31] i2,
                         input logic [0:1] take, input logic fl);
        in_valid = v; in_instr1 = i1; in_instr2 = i2; out_take = take; flush = fl;
    endtask

    // Compare all outputs against the model's view of the head.
    task automatic check_model(input string nm);
        logic [0:31] e1, e2;
        logic        es;
        e1 = NOP; e2 = NOP; es = 1'b0;
        if (q.size() != 0) begin
            if (mhalf) begin
                e1 = q[0].i2; es = 1'b1;
            end else begin
                e1 = q[0].i1; e2 = q[0].i2;
            end
        end
        chk({nm, ".count"}, 32'(count), 32'(q.size()));
        chk({nm, ".in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({nm, ".out_instr1"}, out_instr1, e1);
        chk({nm, ".out_instr2"}, out_instr2, e2);
        chk({nm, ".out_single"}, 32'(out_single), 32'(es));
    endtask

    // One clock with model tracking: check pre-edge outputs, then advance both.
    task automatic cyc(input string nm, input logic v, input logic [0:31] i1,
                       input logic [0:31] i2, input logic [0:1] take, input logic fl);
        bit acc;
        pair_t p;
        drive(v, i1, i2, take, fl);
        check_model(nm);
        acc = v && (q.size() != DEPTH) && !fl;
        if (fl) begin
            q.delete();
            mhalf = 1'b0;
        end else begin
            if (q.size() != 0) begin
                if (take == 2'b11 || (take == 2'b10 && mhalf)) begin
                    void'(q.pop_front());
                    mhalf = 1'b0;
                end else if (take == 2'b10) begin
                    mhalf = 1'b1;
                end
            end
            if (acc) begin
                p.i1 = i1; p.i2 = i2;
                q.push_back(p);
            end
        end
        tick();
    endtask

    localparam logic [0:31] A1 = 32'hA000_0001, A2 = 32'hA000_0002;
    localparam logic [0:31] B1 = 32'hB000_0001, B2 = 32'hB000_0002;
    localparam logic [0:31] C1 = 32'hC000_0001, C2 = 32'hC000_0002;

    initial begin
        // Pre-edge expectations for each row.
        tbl[0]  = mk(0, '0, '0, 2'b00, 0, 1, 0, NOP, NOP, 0, 4'd0);
        tbl[1]  = mk(1, A1, A2, 2'b00, 0, 1, 0, NOP, NOP, 0, 4'd0);
        tbl[2]  = mk(1, B1, B2, 2'b00, 0, 1, 1, A1,  A2,  0, 4'd1);
        tbl[3]  = mk(0, '0, '0, 2'b00, 0, 1, 1, A1,  A2,  0, 4'd2);
        tbl[4]  = mk(0, '0, '0, 2'b11, 0, 1, 1, A1,  A2,  0, 4'd2);
        tbl[5]  = mk(0, '0, '0, 2'b00, 0, 1, 1, B1,  B2,  0, 4'd1);
        tbl[6]  = mk(0, '0, '0, 2'b10, 0, 1, 1, B1,  B2,  0, 4'd1);
        tbl[7]  = mk(0, '0, '0, 2'b00, 0, 1, 1, B2,  NOP, 1, 4'd1);
        tbl[8]  = mk(1, C1, C2, 2'b01, 0, 1, 1, B2,  NOP, 1, 4'd1);
        tbl[9]  = mk(0, '0, '0, 2'b10, 0, 1, 1, B2,  NOP, 1, 4'd2);
        tbl[10] = mk(0, '0, '0, 2'b00, 0, 1, 1, C1,  C2,  0, 4'd1);
        tbl[11] = mk(0, '0, '0, 2'b11, 0, 1, 1, C1,  C2,  0, 4'd1);
        tbl[12] = mk(0, '0, '0, 2'b11, 0, 1, 0, NOP, NOP, 0, 4'd0);
        tbl[13] = mk(0, '0, '0, 2'b10, 0, 1, 0, NOP, NOP, 0, 4'd0);
        tbl[14] = mk(0, '0, '0, 2'b00, 0, 1, 0, NOP, NOP, 0, 4'd0);

        // Reset values while held in reset.
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.out_instr1", out_instr1, NOP);
        chk("rst.out_instr2", out_instr2, NOP);
        chk("rst.out_single", 32'(out_single), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].i1, tbl[i].i2, tbl[i].take, tbl[i].fl);
            chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d.out_instr1", i), out_instr1, tbl[i].e_o1);
            chk($sformatf("row%0d.out_instr2", i), out_instr2, tbl[i].e_o2);
            chk($sformatf("row%0d.out_single", i), 32'(out_single), 32'(tbl[i].e_s));
            chk($sformatf("row%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
            tick();
        end

        // Fill to full; push with pop while full is refused.
        for (int k = 0; k < 8; k++) begin
            cyc("fill", 1, 32'h1000_0000 + k, 32'h1100_0000 + k, 2'b00, 0);
        end
        drive(0, '0, '0, 2'b00, 0);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        chk("full.count", 32'(count), 32'd8);
        cyc("fullpp", 1, 32'hDEAD_0001, 32'hDEAD_0002, 2'b11, 0);
        chk("fullpp.count", 32'(count), 32'd7);
        cyc("pp7", 1, 32'h1000_0008, 32'h1100_0008, 2'b11, 0);
        chk("pp7.count", 32'(count), 32'd7);
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            cyc("drain1", 0, '0, '0, 2'b11, 0);
        end
        chk("drain1.empty", 32'(count), 32'd0);

        // Streaming with wrap-around, mixing half and full pops.
        for (int k = 0; k < 20; k++) begin
            cyc("wrap", 1, 32'h2000_0000 + k, 32'h2100_0000 + k,
                (k % 3 == 2) ? 2'b10 : 2'b11, 0);
        end
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            cyc("drain2", 0, '0, '0, (k % 2 == 0) ? 2'b10 : 2'b11, 0);
        end
        chk("drain2.empty", 32'(count), 32'd0);

        // Flush beats push and pop with a half-consumed head.
        for (int k = 0; k < 5; k++) begin
            cyc("pre_flush", 1, 32'h3000_0000 + k, 32'h3100_0000 + k, 2'b00, 0);
        end
        cyc("half5", 0, '0, '0, 2'b10, 0);
        chk("half5.out_single", 32'(out_single), 32'd1);
        cyc("flush", 1, 32'hDEAD_0003, 32'hDEAD_0004, 2'b11, 1);
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        cyc("post_flush", 1, 32'h4000_0001, 32'h4000_0002, 2'b00, 0);
        chk("post_flush.out_instr1", out_instr1, 32'h4000_0001);
        cyc("post_flush2", 0, '0, '0, 2'b11, 0);

        // Asynchronous reset between edges with three entries held.
        for (int k = 0; k < 3; k++) begin
            cyc("pre_rst", 1, 32'h5000_0000 + k, 32'h5100_0000 + k, 2'b00, 0);
        end
        drive(0, '0, '0, 2'b00, 0);
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        mhalf = 1'b0;
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        chk("arst.out_instr1", out_instr1, NOP);
        chk("arst.out_instr2", out_instr2, NOP);
        chk("arst.out_single", 32'(out_single), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc("empty_take", 0, '0, '0, 2'b11, 0);
        chk("empty_take.count", 32'(count), 32'd0);
        cyc("first_push", 1, 32'h6000_0001, 32'h6000_0002, 2'b00, 0);
        chk("first_push.count", 32'(count), 32'd1);
        check_model("first_push_view");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_pair_queue.md
INSTR_PAIR_QUEUE -- requirements
Module: instr_pair_queue

Interface
REQ-001 Parameter DEPTH, default 8, is the number of instruction-pair entries; it SHALL be a power of two, minimum 2.
REQ-002 Parameter NOP, default 32'h0, is the filler word driven on empty or unused output slots.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: the fetch side presents a pair.
REQ-006 Port in_instr1, input, [0:31]: the first (older) instruction of the pair.
REQ-007 Port in_instr2, input, [0:31]: the second instruction of the pair.
REQ-008 Port in_ready, output, 1 bit: the queue accepts a pair this cycle.
REQ-009 Port out_valid, output, 1 bit: the head slot holds at least one instruction.
REQ-010 Port out_instr1, output, [0:31]: the oldest pending instruction.
REQ-011 Port out_instr2, output, [0:31]: the next-oldest instruction in the head entry, or NOP.
REQ-012 Port out_single, output, 1 bit: only out_instr1 is meaningful.
REQ-013 Port out_take, input, [0:1]: 2'b11 consumes both instructions, 2'b10 consumes out_instr1 only; 2'b00 and 2'b01 consume nothing.
REQ-014 Port flush, input, 1 bit: discards all contents.
REQ-015 Port count, output, [log2(DEPTH):0]: the number of occupied entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries, each holding {instr1, instr2}, indexed by wr_ptr and rd_ptr (log2(DEPTH) bits each), plus an occupancy counter and a half flag.
REQ-017 in_ready SHALL equal (count != DEPTH); no push-through on full, so a full queue refuses input even when a pop occurs in the same cycle.
REQ-018 A push SHALL occur when in_valid and in_ready: the pair is written at wr_ptr, wr_ptr increments modulo DEPTH, and count increments.
REQ-019 out_valid SHALL equal (count != 0); all output words are combinational from the head entry with zero latency.
REQ-020 When half=0, out_instr1 SHALL be head.instr1, out_instr2 SHALL be head.instr2, and out_single SHALL be 0.
REQ-021 When half=1, out_instr1 SHALL be head.instr2, out_instr2 SHALL be NOP, and out_single SHALL be 1.
REQ-022 When out_valid is 0, out_instr1 and out_instr2 SHALL be NOP and out_single SHALL be 0.
REQ-023 A full pop SHALL occur when out_valid and (out_take==2'b11, or out_take==2'b10 with half=1): rd_ptr increments modulo DEPTH, count decrements, and half clears.
REQ-024 A half pop SHALL occur when out_valid, out_take==2'b10 and half=0: half sets, and pointers and count are unchanged.
REQ-025 On a simultaneous push and full pop, count SHALL stay unchanged and both pointers SHALL advance.
REQ-026 When out_valid=0, out_take SHALL be ignored and SHALL cause no state change or underflow.
REQ-027 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless; the data order seen at the output equals the push order.
REQ-028 flush SHALL take priority over push and pop in the same cycle: the next state is wr_ptr=rd_ptr=0, count=0, half=0, and the input pair presented that cycle is dropped.
REQ-029 While flush=1, in_ready SHALL still follow REQ-017, so the source can keep handshaking against the pre-flush occupancy.
REQ-030 Entry storage SHALL NOT require reset; only control state resets.

Reset
REQ-031 While rst=0, immediately and asynchronously: wr_ptr=0, rd_ptr=0, count=0, half=0, out_valid=0, out_single=0, out_instr1=out_instr2=NOP, in_ready=1.
REQ-032 A reset asserted mid-operation SHALL discard all entries, including a half-consumed head.
REQ-033 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Push pairs (A1,A2), then (B1,B2), with out_take=00 -> count=2 and out=(A1,A2,single=0); then out_take=11 -> out=(B1,B2) and count=1.
REQ-035 Head (A1,A2), out_take=10 -> next cycle out=(A2,NOP,single=1) with count unchanged; out_take=10 again -> head becomes the next pair and half=0.
REQ-036 Fill 8 pairs -> in_ready=0 and count=8; a push with simultaneous pop while full is refused and count becomes 7; the next cycle push plus pop leaves count=7.
REQ-037 Perform 20 push/pop cycles with DEPTH=8 -> pointers wrap and the output sequence matches the input sequence exactly.
REQ-038 count=5, half=1, with flush=1, in_valid=1 and out_take=11 in the same cycle -> next cycle count=0, out_valid=0, and the input pair is not stored.
REQ-039 Assert rst=0 asynchronously between edges with count=3 -> outputs reach their reset values before the next clock edge; after release, out_take=11 on empty causes no change.
